serial_frame_tx: RTL and testbench
==================================

Name: serial_frame_tx

Overview:
- Serial framing transmitter: the sending end of our single-wire serial pattern line.
- Accepts a parallel data word over a valid/ready handshake and drives it out on one line: a fixed 3-bit preamble "010", then DATA_W data bits MSB-first, then a stop bit "1".
- Line idles high, so the downstream sequence-detecting receiver sees the preamble as the frame marker.
- Sits between a parallel producer (control logic or test stimulus) and the serial line.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- CLKS_PER_BIT, 1, clk cycles each serial bit is held on b_out (>=1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- data_in  input  DATA_W  payload word; sampled only on acceptance.
- valid_in  input  1  producer has a word available.
- ready  output  1  block can accept a word this cycle.
- b_out  output  1  serial line, registered; idle level 1.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse after a frame's stop bit completes.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, b_out=1, busy=0, frame_done=0, bit timer=0, bit index=0, shift register=0. This overrides any frame in progress. An aborted frame is dropped with no frame_done pulse.
- ready = (state==IDLE) && !rst. It is combinational from state. busy = (state!=IDLE).
- Acceptance happens at an edge with valid_in=1 and ready=1:
  - Latch data_in into the shift register.
  - Go to PRE with b_out<=0 (preamble bit 0) and timer<=0.
  - b_out shows the first preamble bit in the cycle after the accepting edge. Latency from acceptance to first line bit is 1 cycle.
- Bit timing: every line bit is held exactly CLKS_PER_BIT cycles. The timer counts 0..CLKS_PER_BIT-1. The next bit is loaded at the edge where timer==CLKS_PER_BIT-1, and the timer wraps to 0. The timer is ceil(log2(CLKS_PER_BIT+1)) bits wide.
- States:
  - IDLE: b_out=1. Leave only on acceptance.
  - PRE: emit 0,1,0 using a 2-bit preamble index. After the third bit's period, go to DATA with b_out<=shift[DATA_W-1].
  - DATA: emit shift register MSB-first, shifting left one bit per bit period. The index counts 0..DATA_W-1. After the last bit's period, go to STOP with b_out<=1.
  - STOP: hold 1 for one bit period, then go to IDLE with frame_done<=1 for exactly one cycle.
- Frame length: (3+DATA_W+1)*CLKS_PER_BIT cycles, first preamble cycle through last stop cycle.
- Back-to-back frames: ready rises in the first IDLE cycle, which is the frame_done cycle. If valid_in is held high, the next frame is accepted at the end of that cycle. Consecutive frames are separated by exactly 1 idle-high cycle after the stop bit.
- Boundary conditions:
  - valid_in while busy: ignored; no stall or corruption, and the word is not captured.
  - data_in changes mid-frame: no effect.
  - valid_in and rst asserted together: rst wins; nothing is accepted.
  - DATA_W=1: one data bit.
  - CLKS_PER_BIT=1: timer is effectively constant and a bit advances every cycle.
- Outputs b_out and frame_done are registered. No combinational path runs from inputs to b_out.

Test Plan:
- Reset: hold rst 3 cycles mid-idle and mid-frame -> next cycle b_out=1, busy=0, ready=1, frame_done=0; the aborted frame yields no frame_done.
- Single frame, DATA_W=8, CLKS_PER_BIT=1, data_in=0xA5 accepted at edge E0 -> b_out in cycles after E0..E11 = 0,1,0, 1,0,1,0,0,1,0,1, 1. Then b_out=1, frame_done=1 and ready=1 in the cycle after E12; busy=1 for 12 cycles.
- CLKS_PER_BIT=4, data_in=0x3C -> each bit held exactly 4 cycles; frame spans 48 cycles; line pattern 0,1,0,0,0,1,1,1,1,0,0,1, each bit 4 wide.
- Mid-frame interference: accept 0xFF, then during DATA drive data_in=0x00 with valid_in=1 -> line still carries 0xFF, ready stays 0, and the 0x00 word is not sent until it is re-presented after frame_done.
- Back-to-back: valid_in held 1 with 0x81 then 0x7E -> exactly one idle-high cycle between the first stop bit and the second preamble's leading 0; two frame_done pulses 13 cycles apart at CLKS_PER_BIT=1.
- Edge config DATA_W=1, CLKS_PER_BIT=1, data_in=1 -> b_out = 0,1,0,1,1 (stop), then idle; frame_done once.

Source files
------------

// File: rtl/serial_frame_tx.sv
// Serial framing transmitter: sends preamble "010", DATA_W bits MSB-first and a
// stop "1" on an idle-high line, each bit held CLKS_PER_BIT clocks.
module serial_frame_tx #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready,
  output logic              b_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned TMR_W = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    STOP = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [1:0]          pidx_q, pidx_d;
  logic [IDX_W-1:0]    didx_q, didx_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   shift_nxt;
  logic                b_out_q, b_out_d;
  logic                done_q, done_d;
  logic                bit_end;
  logic                accept;

  assign ready      = (state_q == IDLE) && !rst;
  assign busy       = (state_q != IDLE);
  assign b_out      = b_out_q;
  assign frame_done = done_q;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      pidx_q  <= '0;
      didx_q  <= '0;
      shift_q <= '0;
      b_out_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      pidx_q  <= pidx_d;
      didx_q  <= didx_d;
      shift_q <= shift_d;
      b_out_q <= b_out_d;
      done_q  <= done_d;
    end
  end

  // Next-state: the line value for the next bit is loaded at the last clock of the current bit
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    pidx_d    = pidx_q;
    didx_d    = didx_q;
    shift_d   = shift_q;
    b_out_d   = b_out_q;
    done_d    = 1'b0;
    bit_end   = (timer_q == TMR_LAST);
    accept    = valid_in && ready;
    shift_nxt = shift_q << 1;

    if (state_q != IDLE) begin
      timer_d = bit_end ? '0 : timer_q + TMR_W'(1);
    end

    case (state_q)
      IDLE: begin
        b_out_d = 1'b1;
        if (accept) begin
          shift_d = data_in;
          state_d = PRE;
          b_out_d = 1'b0;
          timer_d = '0;
          pidx_d  = '0;
        end
      end
      PRE: begin
        if (bit_end) begin
          if (pidx_q == 2'd2) begin
            state_d = DATA;
            didx_d  = '0;
            b_out_d = shift_q[DATA_W-1];
          end else begin
            pidx_d  = pidx_q + 2'd1;
            b_out_d = (pidx_q == 2'd0);
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          if (didx_q == IDX_LAST) begin
            state_d = STOP;
            b_out_d = 1'b1;
          end else begin
            didx_d  = didx_q + IDX_W'(1);
            shift_d = shift_nxt;
            b_out_d = shift_nxt[DATA_W-1];
          end
        end
      end
      STOP: begin
        b_out_d = 1'b1;
        if (bit_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        b_out_d = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three configurations compared every cycle against a
// queue-of-line-bits reference model, with directed and random stimulus.
module tb_serial_frame_tx;

  logic       clk;
  logic       rst;
  logic       valid_a [3];
  logic [7:0] data_a  [3];
  logic [0:0] data_w1;
  logic       ready_a [3];
  logic       b_a     [3];
  logic       busy_a  [3];
  logic       done_a  [3];

  int n_checks;
  int n_pass;
  int cyc;
  int k;

  bit mq[$];
  bit mdone;

  assign data_w1 = data_a[2][0:0];

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) u0 (
    .clk(clk), .rst(rst), .data_in(data_a[0]), .valid_in(valid_a[0]),
    .ready(ready_a[0]), .b_out(b_a[0]), .busy(busy_a[0]), .frame_done(done_a[0]));

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) u1 (
    .clk(clk), .rst(rst), .data_in(data_a[1]), .valid_in(valid_a[1]),
    .ready(ready_a[1]), .b_out(b_a[1]), .busy(busy_a[1]), .frame_done(done_a[1]));

  serial_frame_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) u2 (
    .clk(clk), .rst(rst), .data_in(data_w1), .valid_in(valid_a[2]),
    .ready(ready_a[2]), .b_out(b_a[2]), .busy(busy_a[2]), .frame_done(done_a[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cfg%0d cycle %0d: got %0h expected %0h", tag, k, cyc, obs, exp);
  endtask

  // Whole frame as line bits, each repeated for the configured bit period
  task automatic push_frame(input logic [7:0] d);
    int dw;
    int cpb;
    bit b;
    dw  = (k == 2) ? 1 : 8;
    cpb = (k == 1) ? 4 : 1;
    for (int i = 0; i < dw + 4; i++) begin
      if (i == 0 || i == 2)   b = 1'b0;
      else if (i == 1)        b = 1'b1;
      else if (i == dw + 3)   b = 1'b1;
      else                    b = d[dw - 1 - (i - 3)];
      for (int j = 0; j < cpb; j++) mq.push_back(b);
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare
  task automatic step();
    logic       v;
    logic [7:0] d;
    logic       r;
    logic       eb;
    v = valid_a[k];
    d = data_a[k];
    r = rst;
    @(posedge clk);
    cyc++;
    if (r) begin
      mq.delete();
      mdone = 1'b0;
    end else if (mq.size() == 0) begin
      mdone = 1'b0;
      if (v) push_frame(d);
    end else begin
      void'(mq.pop_front());
      mdone = (mq.size() == 0);
    end
    #1;
    eb = (mq.size() != 0) ? mq[0] : 1'b1;
    check("b_out", 32'(b_a[k]), 32'(eb));
    check("busy", 32'(busy_a[k]), 32'(mq.size() != 0));
    check("ready", 32'(ready_a[k]), 32'((mq.size() == 0) && !rst));
    check("frame_done", 32'(done_a[k]), 32'(mdone));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] d);
    valid_a[k] = 1'b1;
    data_a[k]  = d;
    step();
    valid_a[k] = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    k        = 0;
    mdone    = 1'b0;
    rst      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      valid_a[i] = 1'b0;
      data_a[i]  = 8'h00;
    end

    // Reset while idle, with valid asserted alongside
    valid_a[0] = 1'b1;
    data_a[0]  = 8'h5A;
    run(3);
    valid_a[0] = 1'b0;
    rst = 1'b0;
    run(2);

    // Single 0xA5 frame
    send(8'hA5);
    run(15);

    // Reset mid-frame drops the frame without a done pulse
    send(8'hC3);
    run(6);
    rst = 1'b1;
    valid_a[0] = 1'b1;
    run(3);
    rst = 1'b0;
    valid_a[0] = 1'b0;
    run(16);

    // Interference while busy: 0x00 held until it is taken after frame_done
    send(8'hFF);
    run(4);
    valid_a[0] = 1'b1;
    data_a[0]  = 8'h00;
    run(9);
    valid_a[0] = 1'b0;
    run(3);
    valid_a[0] = 1'b1;
    run(1);
    valid_a[0] = 1'b0;
    run(15);

    // Back-to-back 0x81 then 0x7E with valid held
    valid_a[0] = 1'b1;
    data_a[0]  = 8'h81;
    step();
    data_a[0]  = 8'h7E;
    run(13);
    valid_a[0] = 1'b0;
    run(15);

    // Four clocks per bit, 0x3C
    k = 1;
    send(8'h3C);
    run(52);

    // One-bit payload
    k = 2;
    send(8'h01);
    run(7);
    send(8'h00);
    run(7);

    // Random traffic on each configuration, with sparse resets
    for (int c = 0; c < 3; c++) begin
      k = c;
      for (int i = 0; i < 400; i++) begin
        valid_a[k] = ($urandom_range(0, 3) != 0);
        data_a[k]  = 8'($urandom);
        rst        = ($urandom_range(0, 60) == 0);
        step();
      end
      valid_a[k] = 1'b0;
      rst = 1'b0;
      run(60);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
